// File: rtl/cv32e40p_cluster_clk_ctrl.sv
// Cluster clock-gating controller: guarded sleep entry, sticky interrupt pending, masked one-cycle wake.
// Optional macro CLUSTER_CLK_CTRL_WAKE_CNT_EN adds a saturating 16-bit SLEEP->WAKE counter on wake_cnt_o.
module cv32e40p_cluster_clk_ctrl #(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned NUM_IRQ      = 32
) (
    input  logic               clk_ungated_i,
    input  logic               rst_n,
    input  logic               core_sleep_i,
    input  logic [NUM_IRQ-1:0] irq_evt_i,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_ack_id_i,
    input  logic               debug_req_i,
    output logic               pulp_clock_en_o,
    output logic [NUM_IRQ-1:0] irq_o,
    output logic               debug_req_o,
    output logic               sleeping_o,
    output logic [15:0]        wake_cnt_o
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        SLEEP_PEND = 2'd1,
        SLEEP      = 2'd2,
        WAKE       = 2'd3
    } state_e;

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [3:0]         guard_cnt_q, guard_cnt_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic               wake_c;

    assign wake_c = (|pend_q) | (|irq_evt_i) | debug_req_i;

    // Acks with an id outside the implemented lines match no bit; a new event beats a same-cycle ack.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_ack_i && (irq_ack_id_i == 5'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
        pend_d = pend_d | irq_evt_i;
    end

    always_comb begin
        state_d         = state_q;
        guard_cnt_d     = guard_cnt_q;
        pulp_clock_en_o = 1'b1;
        irq_o           = '0;
        debug_req_o     = 1'b0;
        sleeping_o      = 1'b0;
        case (state_q)
            RUN: begin
                irq_o       = pend_q;
                debug_req_o = debug_req_i;
                if (core_sleep_i && !wake_c) begin
                    state_d     = SLEEP_PEND;
                    guard_cnt_d = GUARD_LOAD;
                end
            end
            SLEEP_PEND: begin
                irq_o       = pend_q;
                debug_req_o = debug_req_i;
                if (!core_sleep_i || wake_c) begin
                    state_d     = RUN;
                    guard_cnt_d = '0;
                end else if (guard_cnt_q == 4'd0) begin
                    state_d = SLEEP;
                end else begin
                    guard_cnt_d = guard_cnt_q - 4'd1;
                end
            end
            SLEEP: begin
                pulp_clock_en_o = 1'b0;
                sleeping_o      = 1'b1;
                if (wake_c || !core_sleep_i) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                // Clock runs again but requests stay masked until the core is clocked.
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            guard_cnt_q <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            pend_q      <= pend_d;
        end
    end

`ifdef CLUSTER_CLK_CTRL_WAKE_CNT_EN
    logic [15:0] wake_cnt_q, wake_cnt_d;

    always_comb begin
        wake_cnt_d = wake_cnt_q;
        if ((state_q == SLEEP) && (state_d == WAKE) && (wake_cnt_q != 16'hFFFF)) begin
            wake_cnt_d = wake_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            wake_cnt_q <= '0;
        end else begin
            wake_cnt_q <= wake_cnt_d;
        end
    end

    assign wake_cnt_o = wake_cnt_q;
`else
    assign wake_cnt_o = 16'd0;
`endif

endmodule
